masked_rmw_mem: RTL and testbench

// - Parametrised single-port word memory with per-lane write masks and a registered read port.
// - Full-mask writes commit in one cycle.
// - Partial-mask writes run an internal read-modify-write: read the old word, merge, write back.
// - Sits behind a simple valid/ready request channel; read data returns on a response channel.

---
 rtl/masked_rmw_mem.sv | 133 +++++++++++++
 tb/tb_masked_rmw_mem.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/masked_rmw_mem.sv
// Single-port word memory with per-lane write masks and a registered read port.
// Partial-mask writes take one extra MERGE cycle to read, merge and write back the word.
module masked_rmw_mem #(
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int REQ_ADDR_W = 32,
  localparam int MASK_W    = DATA_W / LANE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic                  io_req_write,
  input  logic [REQ_ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0]     io_req_data,
  input  logic [MASK_W-1:0]     io_req_mask,
  output logic                  io_resp_valid,
  output logic [DATA_W-1:0]     io_resp_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    MERGE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  logic [ADDR_W-1:0]   req_idx;
  logic                req_fire;

  function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] e;
    for (int i = 0; i < MASK_W; i++) begin
      e[i*LANE_W +: LANE_W] = {LANE_W{m[i]}};
    end
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] bm;
    bm = expand_mask(m);
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  assign req_idx  = io_req_addr[ADDR_W-1:0];
  assign req_fire = io_req_valid && io_req_ready;

  // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
  generate
    if (REQ_ADDR_W > ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^io_req_addr[REQ_ADDR_W-1:ADDR_W];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    mask_d       = mask_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    mem_we       = 1'b0;
    mem_wa       = req_idx;
    mem_wd       = io_req_data;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (!io_req_write) begin
            resp_valid_d = 1'b1;
            resp_data_d  = mem_q[req_idx];
          end else if (&io_req_mask) begin
            mem_we = 1'b1;
          end else if (|io_req_mask) begin
            idx_d   = req_idx;
            data_d  = io_req_data;
            mask_d  = io_req_mask;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        mem_we  = 1'b1;
        mem_wa  = idx_q;
        mem_wd  = merge_word(mem_q[idx_q], data_q, mask_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Holding registers only matter while in MERGE, which reset always leaves.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
    mask_q <= mask_d;
    if (mem_we && !reset) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign io_req_ready  = (state_q == IDLE);
  assign io_resp_valid = resp_valid_q;
  assign io_resp_data  = resp_data_q;

endmodule

// File: tb/tb_masked_rmw_mem.sv
// Bench for masked_rmw_mem: table of requests with expected read data, a response
// scoreboard queue, and hand-written reset-during-MERGE and reset-priority sequences.
module tb_masked_rmw_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_req_write;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_data;
  logic [3:0]  io_req_mask;
  logic        io_resp_valid;
  logic [31:0] io_resp_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  masked_rmw_mem #(
    .DATA_W(32), .LANE_W(8), .ADDR_W(3), .REQ_ADDR_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_req_valid(io_req_valid),
    .io_req_ready(io_req_ready),
    .io_req_write(io_req_write),
    .io_req_addr(io_req_addr),
    .io_req_data(io_req_data),
    .io_req_mask(io_req_mask),
    .io_resp_valid(io_resp_valid),
    .io_resp_data(io_resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [31:0] exp, output int waited);
    logic [31:0] popped;
    bit merge;
    io_req_valid = 1'b1;
    io_req_write = wr;
    io_req_addr  = addr;
    io_req_data  = data;
    io_req_mask  = mask;
    waited = 0;
    while (!io_req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!io_req_ready) begin
      check("accept_timeout", 64'(waited), 64'd0);
      io_req_valid = 1'b0;
    end else begin
      if (!wr) sb.push_back(exp);
      @(negedge clk);
      io_req_valid = 1'b0;
      if (!wr) begin
        check("resp_valid_latency", 64'(io_resp_valid), 64'd1);
        if (sb.size() > 0) begin
          popped = sb.pop_front();
          check("resp_data", 64'(io_resp_data), 64'(popped));
        end else begin
          check("scoreboard_underflow", 64'(sb.size()), 64'd1);
        end
      end else begin
        merge = (mask != 4'h0) && (mask != 4'hF);
        check("ready_after_write", 64'(io_req_ready), 64'(!merge));
        check("no_resp_on_write", 64'(io_resp_valid), 64'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  prev_merge;

    vecs[0]  = '{1'b1, 32'h2,        32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h2,        32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h3,        32'h11223344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h3,        32'hAABBCCDD, 4'h3, 32'h0};
    vecs[4]  = '{1'b0, 32'h3,        32'h0,        4'h0, 32'h1122CCDD};
    vecs[5]  = '{1'b1, 32'h0000000B, 32'h55AA55AA, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 32'h3,        32'h0,        4'h0, 32'h55AA55AA};
    vecs[7]  = '{1'b1, 32'h4,        32'h01020304, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, 32'h4,        32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[9]  = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h01020304};
    vecs[10] = '{1'b1, 32'h5,        32'h00000011, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 32'h5,        32'h7F000000, 4'h8, 32'h0};
    vecs[12] = '{1'b0, 32'h5,        32'h0,        4'h0, 32'h7F000011};
    vecs[13] = '{1'b0, 32'h2,        32'h0,        4'h0, 32'hDEADBEEF};
    vecs[14] = '{1'b0, 32'hFFFFFFFA, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[15] = '{1'b1, 32'h7,        32'h00000000, 4'hF, 32'h0};
    vecs[16] = '{1'b1, 32'h7,        32'hFFFFFFFF, 4'h5, 32'h0};
    vecs[17] = '{1'b1, 32'h6,        32'h12345678, 4'hF, 32'h0};
    vecs[18] = '{1'b0, 32'h7,        32'h0,        4'h0, 32'h00FF00FF};
    vecs[19] = '{1'b0, 32'h6,        32'h0,        4'h0, 32'h12345678};

    reset = 1'b1;
    io_req_valid = 1'b0;
    io_req_write = 1'b0;
    io_req_addr  = '0;
    io_req_data  = '0;
    io_req_mask  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_ready", 64'(io_req_ready), 64'd1);
    check("reset_resp_valid", 64'(io_resp_valid), 64'd0);
    check("reset_resp_data", 64'(io_resp_data), 64'd0);

    prev_merge = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].exp, w);
      check($sformatf("wait_cycles_row%0d", i), 64'(w), prev_merge ? 64'd1 : 64'd0);
      prev_merge = vecs[i].wr && (vecs[i].mask != 4'h0) && (vecs[i].mask != 4'hF);
    end

    // Reset during MERGE: write-back suppressed, outputs cleared.
    do_req(1'b1, 32'h1, 32'h00000000, 4'hF, 32'h0, w);
    do_req(1'b1, 32'h1, 32'hFFFFFFFF, 4'h3, 32'h0, w);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_merge_ready", 64'(io_req_ready), 64'd1);
    check("rst_merge_resp_valid", 64'(io_resp_valid), 64'd0);
    check("rst_merge_resp_data", 64'(io_resp_data), 64'd0);
    do_req(1'b0, 32'h1, 32'h0, 4'h0, 32'h00000000, w);
    check("rst_merge_wait", 64'(w), 64'd0);

    // Reset has priority over a request presented in the same cycle.
    reset        = 1'b1;
    io_req_valid = 1'b1;
    io_req_write = 1'b1;
    io_req_addr  = 32'h6;
    io_req_data  = 32'hAAAAAAAA;
    io_req_mask  = 4'hF;
    @(negedge clk);
    reset        = 1'b0;
    io_req_valid = 1'b0;
    do_req(1'b0, 32'h6, 32'h0, 4'h0, 32'h12345678, w);

    @(negedge clk);
    check("resp_valid_drops", 64'(io_resp_valid), 64'd0);
    check("resp_data_holds", 64'(io_resp_data), 64'h12345678);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
